// File: rtl/pc_unit_ras_if.sv
// pc_unit_ras_if: control inputs and PC/RAS status outputs of the fetch-PC unit
interface pc_unit_ras_if #(parameter int ADDR_W = 30, parameter int RAS_DEPTH = 4);
  logic stall, exc, br_taken, jmp, jr, is_call, is_ret;
  logic [15:0] br_off;
  logic [25:0] jmp_imm;
  logic [31:0] jr_target;
  logic [ADDR_W-1:0] pc, npc;
  logic ras_hit, ras_mispred;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  modport master (
    output stall, exc, br_taken, br_off, jmp, jmp_imm, jr, jr_target, is_call, is_ret,
    input pc, npc, ras_hit, ras_mispred, ras_count
  );
  modport slave (
    input stall, exc, br_taken, br_off, jmp, jmp_imm, jr, jr_target, is_call, is_ret,
    output pc, npc, ras_hit, ras_mispred, ras_count
  );
endinterface

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: registered fetch PC with next-PC selection and a circular return-address stack
module pc_unit_ras #(
  parameter int ADDR_W = 30,
  parameter int RAS_DEPTH = 4,
  parameter bit RAS_EN = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h0000_0C00,
  parameter logic [ADDR_W-1:0] EXC_PC = 'h0000_1060
) (
  input logic clk,
  input logic rst,
  pc_unit_ras_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(27'h3FF_FFFF);
  logic [ADDR_W-1:0] pcReg, npc, pcInc, brTgt, jmpTgt, jrWord, rasTop;
  logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
  logic [PW-1:0] wrPtr, topIdx;
  logic [CW-1:0] rasCnt;
  logic hit, upd, push;
  logic unusedBits;
  assign unusedBits = ^bus.jr_target[1:0];
  assign topIdx = wrPtr - 1'b1;
  assign rasTop = rasMem[topIdx];
  assign pcInc = pcReg + 1'b1;
  assign brTgt = pcReg + {{(ADDR_W-16){bus.br_off[15]}}, bus.br_off};
  assign jmpTgt = (pcReg & HI_MASK) | ADDR_W'(bus.jmp_imm);
  assign jrWord = bus.jr_target[ADDR_W+1:2];
  // A pop is exactly a return that consumed the RAS top.
  assign hit = RAS_EN && !rst && !bus.exc && bus.jr && bus.is_ret && rasCnt != '0;
  assign upd = !rst && !bus.exc && (!bus.stall || bus.jr || bus.jmp || bus.br_taken);
  assign push = RAS_EN && upd && bus.is_call && (bus.jmp || bus.jr);
  always_comb begin
    npc = bus.exc ? EXC_PC :
          bus.jr ? (hit ? rasTop : jrWord) :
          bus.jmp ? jmpTgt :
          bus.br_taken ? brTgt :
          bus.stall ? pcReg : pcInc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg <= RESET_PC;
      wrPtr <= '0;
      rasCnt <= '0;
    end else begin
      pcReg <= npc;
      if (hit && !push) begin
        wrPtr <= topIdx;
        rasCnt <= rasCnt - 1'b1;
      end else if (push && !hit) begin
        wrPtr <= wrPtr + 1'b1;
        if (rasCnt != CW'(RAS_DEPTH)) rasCnt <= rasCnt + 1'b1;
      end
    end
  end
  // When full, wrPtr already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (push) rasMem[hit ? topIdx : wrPtr] <= pcInc;
  end
  assign bus.pc = pcReg;
  assign bus.npc = npc;
  assign bus.ras_hit = hit;
  assign bus.ras_mispred = hit && rasTop != jrWord;
  assign bus.ras_count = rasCnt;
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: scoreboard bench with a queue-based reference model of the PC and RAS
module tb_pc_unit_ras;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pc_unit_ras_if bus();
  pc_unit_ras dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {string tag; logic [29:0] pc; int cnt;} exp_t;
  exp_t sb[$];
  logic [29:0] mPc;
  logic [29:0] mStack[$];
  int nChecks = 0;
  int nPass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input string tag, input logic r, s, e, b, input logic [15:0] off,
                      input logic j, input logic [25:0] imm, input logic jrr,
                      input logic [31:0] tgt, input logic call, ret);
    logic [29:0] n;
    logic hit, mis, upd, push;
    exp_t x;
    @(negedge clk);
    rst = r; bus.stall = s; bus.exc = e; bus.br_taken = b; bus.br_off = off;
    bus.jmp = j; bus.jmp_imm = imm; bus.jr = jrr; bus.jr_target = tgt;
    bus.is_call = call; bus.is_ret = ret;
    #1;
    hit = !r && !e && jrr && ret && mStack.size() != 0;
    mis = hit && mStack[$] != tgt[31:2];
    n = e ? 30'h1060 : jrr ? (hit ? mStack[$] : tgt[31:2]) : j ? {mPc[29:26], imm} :
        b ? mPc + {{14{off[15]}}, off} : s ? mPc : mPc + 30'd1;
    if (!r) begin
      check({tag, ".npc"}, 32'(bus.npc), 32'(n));
      check({tag, ".cnt0"}, 32'(bus.ras_count), 32'(mStack.size()));
    end
    check({tag, ".hit"}, 32'(bus.ras_hit), 32'(hit));
    check({tag, ".mis"}, 32'(bus.ras_mispred), 32'(mis));
    upd = !r && !e && (!s || jrr || j || b);
    push = upd && call && (j || jrr);
    if (r) begin
      n = 30'hC00;
      mStack.delete();
    end else if (push && hit) mStack[mStack.size()-1] = mPc + 30'd1;
    else if (hit) void'(mStack.pop_back());
    else if (push) begin
      mStack.push_back(mPc + 30'd1);
      if (mStack.size() > 4) void'(mStack.pop_front());
    end
    mPc = n;
    sb.push_back('{tag, n, mStack.size()});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, ".pc"}, 32'(bus.pc), 32'(x.pc));
    check({x.tag, ".cnt"}, 32'(bus.ras_count), 32'(x.cnt));
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0);
  endtask
  task automatic jump(input string tag, input logic [25:0] imm, input logic call);
    step(tag, 0, 0, 0, 0, 16'h0, 1, imm, 0, 32'h0, call, 0);
  endtask
  task automatic ret(input string tag, input logic [31:0] tgt);
    step(tag, 0, 0, 0, 0, 16'h0, 0, 26'h0, 1, tgt, 0, 1);
  endtask

  initial begin
    mPc = '0;
    step("rst0", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0);
    step("rst1", 1, 0, 0, 1, 16'h5, 1, 26'h77, 1, 32'h40, 1, 1);
    check("t1.reset", 32'(bus.pc), 32'hC00);
    idle("t1.i0");
    check("t1.seq1", 32'(bus.pc), 32'hC01);
    idle("t1.i1");
    check("t1.seq2", 32'(bus.pc), 32'hC02);
    repeat (3) idle("t2.i");
    step("t2.br", 0, 0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0, 0);
    check("t2.brpc", 32'(bus.pc), 32'hC03);
    repeat (2) idle("t2.i2");
    step("t2.brst", 0, 1, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0, 0);
    check("t2.brstpc", 32'(bus.pc), 32'hC03);
    step("t2.stall", 0, 1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0);
    jump("t3.j", 26'hC10, 0);
    jump("t3.call", 26'h40, 1);
    check("t3.callpc", 32'(bus.pc), 32'h40);
    check("t3.callcnt", 32'(bus.ras_count), 32'd1);
    idle("t3.i");
    ret("t3.ret", 32'h3044);
    check("t3.retpc", 32'(bus.pc), 32'hC11);
    check("t3.retcnt", 32'(bus.ras_count), 32'd0);
    jump("t4.j", 26'h100, 0);
    for (int i = 1; i <= 5; i++) jump("t4.call", 26'(32'h100 + i), 1);
    check("t4.full", 32'(bus.ras_count), 32'd4);
    ret("t4.r0", 32'(30'h105) << 2);
    check("t4.r0pc", 32'(bus.pc), 32'h105);
    ret("t4.r1bad", 32'h0000_4000);
    check("t4.r1pc", 32'(bus.pc), 32'h104);
    ret("t4.r2", 32'(30'h103) << 2);
    ret("t4.r3", 32'(30'h102) << 2);
    check("t4.r3pc", 32'(bus.pc), 32'h102);
    ret("t4.r4empty", 32'h0000_2000);
    check("t4.r4pc", 32'(bus.pc), 32'h800);
    jump("t5.call", 26'h200, 1);
    step("t5.exc", 0, 1, 1, 0, 16'h0, 0, 26'h0, 1, 32'h0, 0, 1);
    check("t5.excpc", 32'(bus.pc), 32'h1060);
    check("t5.exccnt", 32'(bus.ras_count), 32'd1);
    step("t5.jalr", 0, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_1234, 1, 1);
    check("t5.jalrcnt", 32'(bus.ras_count), 32'd1);
    ret("t5.ret", 32'(30'h1061) << 2);
    step("t5.br", 0, 0, 0, 1, 16'h0010, 0, 26'h0, 0, 32'h0, 1, 0);
    step("t6.jr", 0, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 0);
    check("t6.top", 32'(bus.pc), 32'h3FFF_FFFF);
    idle("t6.wrap");
    check("t6.wrappc", 32'(bus.pc), 32'h0);
    jump("t7.call", 26'h300, 1);
    jump("t7.call2", 26'h310, 1);
    step("t7.rst", 1, 0, 0, 0, 16'h0, 1, 26'h55, 0, 32'h0, 1, 0);
    check("t7.rstpc", 32'(bus.pc), 32'hC00);
    check("t7.rstcnt", 32'(bus.ras_count), 32'd0);
    idle("t7.i");
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
